// File: rtl/cnt_reg_to_obi.sv
// Register-interface to OBI initiator bridge: one outstanding transaction, registered request and read data.
// Optional rvalid timeout with stale-response tracking is enabled by defining CNT_REG_TO_OBI_TIMEOUT_EN.

package cnt_reg_pkg;
  localparam int unsigned REG_DW  = 32;
  localparam int unsigned REG_AW  = 32;
  localparam int unsigned REG_BEW = REG_DW / 8;

  typedef struct packed {
    logic                valid;
    logic                write;
    logic [REG_BEW-1:0]  wstrb;
    logic [REG_AW-1:0]   addr;
    logic [REG_DW-1:0]   wdata;
  } reg_req_t;

  typedef struct packed {
    logic                error;
    logic                ready;
    logic [REG_DW-1:0]   rdata;
  } reg_resp_t;
endpackage

package cnt_obi_pkg;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_BEW = OBI_DW / 8;

  typedef struct packed {
    logic                req;
    logic                we;
    logic [OBI_BEW-1:0]  be;
    logic [OBI_AW-1:0]   addr;
    logic [OBI_DW-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    logic [OBI_DW-1:0]   rdata;
  } obi_resp_t;
endpackage

module cnt_reg_to_obi #(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned BEW           = DW / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  cnt_reg_pkg::reg_req_t  reg_req_i,
  output cnt_reg_pkg::reg_resp_t reg_rsp_o,
  output cnt_obi_pkg::obi_req_t  obi_req_o,
  input  cnt_obi_pkg::obi_resp_t obi_rsp_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cnt_reg_to_obi: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [BEW-1:0]  be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            timeout_hit;
  logic            stale_reject;

`ifdef CNT_REG_TO_OBI_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;
  logic             err_q, err_d;

  // The limit is reached on the WAIT cycle that would step the counter to TIMEOUT_CYCLES.
  assign timeout_hit  = (state_q == WAIT) && !obi_rsp_i.rvalid &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign stale_reject = (state_q == IDLE) && reg_req_i.valid && stale_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != WAIT) begin
      cnt_d = '0;
    end else if (!obi_rsp_i.rvalid) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A late response belonging to an abandoned transaction is swallowed wherever it shows up.
  always_comb begin
    stale_d = stale_q;
    if (stale_q && obi_rsp_i.rvalid) begin
      stale_d = 1'b0;
    end
    if (timeout_hit) begin
      stale_d = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (state_q != DONE) begin
      err_d = timeout_hit | stale_reject;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      err_q   <= err_d;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign stale_reject = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (stale_reject) begin
          state_d = DONE;
        end else if (reg_req_i.valid) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (obi_rsp_i.gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (obi_rsp_i.rvalid || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if ((state_q == IDLE) && reg_req_i.valid) begin
      we_d    = reg_req_i.write;
      be_d    = reg_req_i.wstrb;
      addr_d  = reg_req_i.addr;
      wdata_d = reg_req_i.wdata;
    end
    if ((state_q == WAIT) && obi_rsp_i.rvalid) begin
      rdata_d = obi_rsp_i.rdata;
    end
    if (timeout_hit || stale_reject) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    obi_req_o       = '0;
    obi_req_o.req   = (state_q == REQ);
    obi_req_o.we    = we_q;
    obi_req_o.be    = be_q;
    obi_req_o.addr  = addr_q;
    obi_req_o.wdata = wdata_q;

    reg_rsp_o       = '0;
    reg_rsp_o.ready = (state_q == DONE);
    reg_rsp_o.rdata = rdata_q;
`ifdef CNT_REG_TO_OBI_TIMEOUT_EN
    reg_rsp_o.error = (state_q == DONE) && err_q;
`else
    reg_rsp_o.error = 1'b0;
`endif
  end

endmodule

// File: tb/tb_cnt_reg_to_obi.sv
// Directed bench for cnt_reg_to_obi: read, stalled write, back-to-back, reset abort, and timeout cases.
module tb_cnt_reg_to_obi;

  logic clk = 1'b0;
  logic rst;

  cnt_reg_pkg::reg_req_t  reg_req;
  cnt_reg_pkg::reg_resp_t reg_rsp;
  cnt_obi_pkg::obi_req_t  obi_req;
  cnt_obi_pkg::obi_resp_t obi_rsp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cnt_reg_to_obi #(
    .DW            (32),
    .AW            (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .reg_req_i(reg_req),
    .reg_rsp_o(reg_rsp),
    .obi_req_o(obi_req),
    .obi_rsp_i(obi_rsp)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each call lands 1 ns after a rising edge: outputs are settled and new inputs apply to the next edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    reg_req.valid = 1'b1;
    reg_req.write = wr;
    reg_req.addr  = a;
    reg_req.wdata = d;
    reg_req.wstrb = s;
  endtask

  initial begin
    rst     = 1'b1;
    reg_req = '0;
    obi_rsp = '0;
    tick;
    tick;
    check_val("rst_req",   32'(obi_req.req),   0);
    check_val("rst_addr",  obi_req.addr,       0);
    check_val("rst_ready", 32'(reg_rsp.ready), 0);
    check_val("rst_error", 32'(reg_rsp.error), 0);
    check_val("rst_rdata", reg_rsp.rdata,      0);
    rst = 1'b0;
    tick;

    // Read: gnt at cycle 1, rvalid at cycle 3, ready at cycle 4
    start_req(1'b0, 32'h10, 32'h0, 4'hF);
    check_val("rd_c0_req", 32'(obi_req.req), 0);
    tick;
    check_val("rd_c1_req",  32'(obi_req.req), 1);
    check_val("rd_c1_addr", obi_req.addr,      32'h10);
    check_val("rd_c1_we",   32'(obi_req.we),   0);
    obi_rsp.gnt = 1'b1;
    tick;
    check_val("rd_c2_req", 32'(obi_req.req), 0);
    obi_rsp.gnt = 1'b0;
    tick;
    check_val("rd_c3_ready", 32'(reg_rsp.ready), 0);
    check_val("rd_c3_req",   32'(obi_req.req),   0);
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'hDEADBEEF;
    tick;
    check_val("rd_c4_ready", 32'(reg_rsp.ready), 1);
    check_val("rd_c4_rdata", reg_rsp.rdata,      32'hDEADBEEF);
    check_val("rd_c4_error", 32'(reg_rsp.error), 0);
    obi_rsp       = '0;
    reg_req.valid = 1'b0;
    tick;
    check_val("rd_c5_ready", 32'(reg_rsp.ready), 0);
    check_val("rd_c5_req",   32'(obi_req.req),   0);
    check_val("rd_c5_hold",  reg_rsp.rdata,      32'hDEADBEEF);

    // Write with gnt withheld for 4 cycles
    start_req(1'b1, 32'h20, 32'hA5A5A5A5, 4'b0101);
    tick;
    for (int i = 1; i <= 4; i++) begin
      check_val($sformatf("wr_c%0d_req", i),   32'(obi_req.req), 1);
      check_val($sformatf("wr_c%0d_we", i),    32'(obi_req.we),  1);
      check_val($sformatf("wr_c%0d_addr", i),  obi_req.addr,     32'h20);
      check_val($sformatf("wr_c%0d_wdata", i), obi_req.wdata,    32'hA5A5A5A5);
      check_val($sformatf("wr_c%0d_be", i),    32'(obi_req.be),  32'h5);
      check_val($sformatf("wr_c%0d_ready", i), 32'(reg_rsp.ready), 0);
      tick;
    end
    check_val("wr_c5_req", 32'(obi_req.req), 1);
    obi_rsp.gnt = 1'b1;
    tick;
    check_val("wr_c6_req", 32'(obi_req.req), 0);
    obi_rsp.gnt    = 1'b0;
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'h11112222;
    tick;
    check_val("wr_c7_ready", 32'(reg_rsp.ready), 1);
    check_val("wr_c7_rdata", reg_rsp.rdata,      32'h11112222);
    obi_rsp       = '0;
    reg_req.valid = 1'b0;
    tick;
    check_val("wr_c8_ready", 32'(reg_rsp.ready), 0);

    // Back-to-back with valid held high
    start_req(1'b0, 32'h40, 32'h0, 4'hF);
    tick;
    check_val("b2b_c1_req",  32'(obi_req.req), 1);
    check_val("b2b_c1_addr", obi_req.addr,     32'h40);
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt    = 1'b0;
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'hAAAA0001;
    tick;
    check_val("b2b_c3_ready", 32'(reg_rsp.ready), 1);
    check_val("b2b_c3_rdata", reg_rsp.rdata,      32'hAAAA0001);
    obi_rsp      = '0;
    reg_req.addr = 32'h44;
    tick;
    check_val("b2b_c4_req",   32'(obi_req.req),   0);
    check_val("b2b_c4_ready", 32'(reg_rsp.ready), 0);
    tick;
    check_val("b2b_c5_req",  32'(obi_req.req), 1);
    check_val("b2b_c5_addr", obi_req.addr,     32'h44);
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt    = 1'b0;
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'hBBBB0002;
    tick;
    check_val("b2b_c7_ready", 32'(reg_rsp.ready), 1);
    check_val("b2b_c7_rdata", reg_rsp.rdata,      32'hBBBB0002);
    obi_rsp       = '0;
    reg_req.valid = 1'b0;
    tick;
    check_val("b2b_c8_ready", 32'(reg_rsp.ready), 0);
    check_val("b2b_c8_req",   32'(obi_req.req),   0);

    // Reset pulsed during WAIT
    start_req(1'b1, 32'h50, 32'h12345678, 4'h3);
    tick;
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0;
    rst = 1'b1;
    tick;
    check_val("rstw_req",   32'(obi_req.req),   0);
    check_val("rstw_we",    32'(obi_req.we),    0);
    check_val("rstw_be",    32'(obi_req.be),    0);
    check_val("rstw_addr",  obi_req.addr,       0);
    check_val("rstw_wdata", obi_req.wdata,      0);
    check_val("rstw_ready", 32'(reg_rsp.ready), 0);
    check_val("rstw_rdata", reg_rsp.rdata,      0);
    rst           = 1'b0;
    reg_req.valid = 1'b0;
    tick;
    start_req(1'b0, 32'h60, 32'h0, 4'hF);
    tick;
    check_val("post_rst_req",  32'(obi_req.req), 1);
    check_val("post_rst_addr", obi_req.addr,     32'h60);
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt    = 1'b0;
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'h5A5A5A5A;
    tick;
    check_val("post_rst_ready", 32'(reg_rsp.ready), 1);
    check_val("post_rst_rdata", reg_rsp.rdata,      32'h5A5A5A5A);
    obi_rsp       = '0;
    reg_req.valid = 1'b0;
    tick;

`ifdef CNT_REG_TO_OBI_TIMEOUT_EN
    // Timeout: 8 WAIT cycles (cycles 2..9) without rvalid, error response at cycle 10
    start_req(1'b0, 32'h30, 32'h0, 4'hF);
    tick;
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0;
    for (int i = 2; i <= 9; i++) begin
      check_val($sformatf("to_c%0d_ready", i), 32'(reg_rsp.ready), 0);
      tick;
    end
    check_val("to_ready", 32'(reg_rsp.ready), 1);
    check_val("to_error", 32'(reg_rsp.error), 1);
    check_val("to_rdata", reg_rsp.rdata,      0);
    reg_req.valid = 1'b0;
    tick;
    start_req(1'b0, 32'h34, 32'h0, 4'hF);
    check_val("stale_c0_req", 32'(obi_req.req), 0);
    tick;
    check_val("stale_req",   32'(obi_req.req),   0);
    check_val("stale_ready", 32'(reg_rsp.ready), 1);
    check_val("stale_error", 32'(reg_rsp.error), 1);
    check_val("stale_rdata", reg_rsp.rdata,      0);
    reg_req.valid = 1'b0;
    tick;
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'h00000099;
    tick;
    obi_rsp = '0;
    check_val("stale_drop_ready", 32'(reg_rsp.ready), 0);
    check_val("stale_drop_rdata", reg_rsp.rdata,      0);
    start_req(1'b0, 32'h38, 32'h0, 4'hF);
    tick;
    check_val("after_stale_req", 32'(obi_req.req), 1);
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt    = 1'b0;
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'hCAFEF00D;
    tick;
    check_val("after_stale_ready", 32'(reg_rsp.ready), 1);
    check_val("after_stale_error", 32'(reg_rsp.error), 0);
    check_val("after_stale_rdata", reg_rsp.rdata,      32'hCAFEF00D);
    obi_rsp       = '0;
    reg_req.valid = 1'b0;
    tick;

    // Race: rvalid on the 8th WAIT cycle wins over the timeout
    start_req(1'b0, 32'h3C, 32'h0, 4'hF);
    tick;
    obi_rsp.gnt = 1'b1;
    tick;
    obi_rsp.gnt = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick;
    end
    check_val("race_c9_ready", 32'(reg_rsp.ready), 0);
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'h600DF00D;
    tick;
    check_val("race_ready", 32'(reg_rsp.ready), 1);
    check_val("race_error", 32'(reg_rsp.error), 0);
    check_val("race_rdata", reg_rsp.rdata,      32'h600DF00D);
    obi_rsp       = '0;
    reg_req.valid = 1'b0;
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
